// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions: polynomial taps, checker state encoding and the next-bit function
// used by both the lfsr generator and the checker.
package prbs_pkg;

    localparam int unsigned PRBS31_LEN = 31;
    localparam int unsigned TAP_A      = 30;
    localparam int unsigned TAP_B      = 27;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSeed  = 2'd1,
        StCheck = 2'd2
    } prbs_state_e;

    // XNOR feedback: all-ones is the lock-up state, all-zeros is a legal seed.
    function automatic logic prbs31_next(input logic [PRBS31_LEN-1:0] hist);
        return ~(hist[TAP_A] ^ hist[TAP_B]);
    endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module prbs_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising serial PRBS31 checker with error counting, loss-of-lock and stuck detection.
// Optional bit_cnt output for BER measurement when PRBS31_CHK_BITCNT_EN is defined.
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             rx_valid,
    input  logic             rx_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             stuck,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sync_lost
`ifdef PRBS31_CHK_BITCNT_EN
    ,
    output logic [CNT_W+8-1:0] bit_cnt
`endif
);

    localparam int unsigned WinW  = $clog2(WIN_LEN);
    localparam int unsigned ErrW  = $clog2(LOSS_THRESH + 1);
    localparam int unsigned SeedW = 5;

    prbs_state_e             state_q, state_d;
    logic [PRBS31_LEN-1:0]   hist_q, hist_d;
    logic [SeedW-1:0]        seed_q, seed_d;
    logic [WinW-1:0]         win_q, win_d;
    logic [ErrW-1:0]         werr_q, werr_d;
    logic                    err_pulse_q, err_pulse_d;
    logic                    sync_lost_q, sync_lost_d;

    logic                    expected;
    logic                    cmp;
    logic                    err_hit;
    logic                    resync;
    logic [ErrW-1:0]         werr_inc;

    assign expected = prbs31_next(hist_q);
    assign cmp      = chk_en && rx_valid && (state_q == StCheck);
    assign err_hit  = cmp && (rx_data != expected);
    assign werr_inc = werr_q + ErrW'(err_hit);

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        seed_d      = seed_q;
        win_d       = win_q;
        werr_d      = werr_q;
        resync      = 1'b0;
        err_pulse_d = err_hit;

        if (!chk_en) begin
            state_d = StIdle;
            hist_d  = '0;
            seed_d  = '0;
            win_d   = '0;
            werr_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSeed;
                    hist_d  = '0;
                    seed_d  = '0;
                    win_d   = '0;
                    werr_d  = '0;
                end
                StSeed: begin
                    if (rx_valid) begin
                        hist_d = {hist_q[PRBS31_LEN-2:0], rx_data};
                        if (seed_q == SeedW'(PRBS31_LEN - 1)) begin
                            state_d = StCheck;
                            seed_d  = '0;
                        end else begin
                            seed_d = seed_q + SeedW'(1);
                        end
                    end
                end
                StCheck: begin
                    if (rx_valid) begin
                        // Received bit goes into history so one line error costs exactly 3 hits.
                        hist_d = {hist_q[PRBS31_LEN-2:0], rx_data};
                        if (werr_inc == ErrW'(LOSS_THRESH)) begin
                            state_d = StSeed;
                            resync  = 1'b1;
                            seed_d  = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else if (win_q == WinW'(WIN_LEN - 1)) begin
                            win_d  = '0;
                            werr_d = '0;
                        end else begin
                            win_d  = win_q + WinW'(1);
                            werr_d = werr_inc;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (err_clr) begin
            sync_lost_d = 1'b0;
        end else begin
            sync_lost_d = sync_lost_q | resync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hist_q      <= '0;
            seed_q      <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_pulse_q <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            seed_q      <= seed_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_pulse_q <= err_pulse_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    prbs_sat_cnt #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .inc(err_hit),
        .clr(err_clr),
        .cnt(err_cnt)
    );

`ifdef PRBS31_CHK_BITCNT_EN
    prbs_sat_cnt #(
        .W(CNT_W + 8)
    ) u_bit_cnt (
        .clk(clk),
        .rst(rst),
        .inc(cmp),
        .clr(err_clr),
        .cnt(bit_cnt)
    );
`endif

    assign stuck     = (state_q == StCheck) && (&hist_q);
    assign locked    = (state_q == StCheck) && !stuck;
    assign err_pulse = err_pulse_q;
    assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: an in-bench PRBS31 source drives the checker through lock,
// single/burst errors, stuck input, saturation, gapped valid and mid-run reset.
module tb_prbs31_checker;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             chk_en;
    logic             rx_valid;
    logic             rx_data;
    logic             err_clr;
    logic             locked;
    logic             stuck;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic             sync_lost;
`ifdef PRBS31_CHK_BITCNT_EN
    logic [CNT_W+7:0] bit_cnt;
`endif

    logic [30:0] gen;
    int          n_chk     = 0;
    int          n_pass    = 0;
    int          pulse_cnt = 0;
    bit          found;

    always #5 clk = ~clk;

    prbs31_checker #(
        .CNT_W(CNT_W),
        .WIN_LEN(64),
        .LOSS_THRESH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .chk_en(chk_en),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .err_clr(err_clr),
        .locked(locked),
        .stuck(stuck),
        .err_pulse(err_pulse),
        .err_cnt(err_cnt),
        .sync_lost(sync_lost)
`ifdef PRBS31_CHK_BITCNT_EN
        ,
        .bit_cnt(bit_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // mode 0: clean PRBS, 1: inverted bit, 2: forced one
    task automatic drive(input bit v, input int mode);
        logic b;
        b = 1'b0;
        if (v) begin
            b   = ~(gen[30] ^ gen[27]);
            gen = {gen[29:0], b};
            if (mode == 1) b = ~b;
            else if (mode == 2) b = 1'b1;
        end
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        #1;
        if (err_pulse) pulse_cnt++;
    endtask

    task automatic relock(input bit half);
        chk_en  = 1'b0;
        err_clr = 1'b1;
        drive(1'b0, 0);
        err_clr = 1'b0;
        chk_en  = 1'b1;
        drive(1'b0, 0);
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 0);
            if (i == 29) chk("lock_early", locked, 0);
            if (half) drive(1'b0, 0);
        end
        chk("lock_time", locked, 1);
    endtask

    initial begin
        rst      = 1'b1;
        chk_en   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 1'b0;
        err_clr  = 1'b0;
        gen      = 31'h1234567;
        repeat (3) drive(1'b0, 0);
        chk("rst_locked", locked, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_sync_lost", sync_lost, 0);

        // Clean stream: SEED on the cycle after enable, CHECK after 31 valid bits.
        rst    = 1'b0;
        chk_en = 1'b1;
        drive(1'b0, 0);
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 0);
            if (i == 29) chk("first_lock_early", locked, 0);
        end
        chk("first_lock", locked, 1);
        pulse_cnt = 0;
        repeat (2000) drive(1'b1, 0);
        chk("clean_pulses", pulse_cnt, 0);
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_sync_lost", sync_lost, 0);
        chk("clean_locked", locked, 1);
        chk("clean_stuck", stuck, 0);
`ifdef PRBS31_CHK_BITCNT_EN
        chk("clean_bit_cnt", bit_cnt, 2000);
`endif

        // Single flipped bit: hits at n, n+28, n+31.
        pulse_cnt = 0;
        drive(1'b1, 1);
        chk("flip_pulse_latency", err_pulse, 1);
        chk("flip_cnt_latency", err_cnt, 1);
        repeat (40) drive(1'b1, 0);
        chk("flip_pulses", pulse_cnt, 3);
        chk("flip_err_cnt", err_cnt, 3);
        chk("flip_locked", locked, 1);

        // Disable keeps err_cnt.
        chk_en = 1'b0;
        drive(1'b1, 0);
        chk("dis_locked", locked, 0);
        chk("dis_err_cnt_kept", err_cnt, 3);
        relock(1'b0);
        chk("relock_err_cnt", err_cnt, 0);

        // Burst of 20 inverted bits, 10 bits into a fresh window.
        repeat (10) drive(1'b1, 0);
        repeat (20) drive(1'b1, 1);
        chk("burst_sync_lost", sync_lost, 1);
        chk("burst_locked", locked, 0);
        chk("burst_err_cnt", err_cnt, 8);
        repeat (18) drive(1'b1, 0);
        chk("burst_relock_early", locked, 0);
        drive(1'b1, 0);
        chk("burst_relock", locked, 1);
        repeat (20) drive(1'b1, 0);
        chk("burst_tail_err_cnt", err_cnt, 11);
        chk("burst_sync_sticky", sync_lost, 1);

        // err_clr clears count and sticky flag; then stuck-at-1 input.
        err_clr = 1'b1;
        drive(1'b1, 0);
        err_clr = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_sync_lost", sync_lost, 0);
        repeat (100) drive(1'b1, 2);
        chk("stuck_flag", stuck, 1);
        chk("stuck_locked", locked, 0);
        err_clr = 1'b1;
        drive(1'b1, 2);
        err_clr   = 1'b0;
        pulse_cnt = 0;
        repeat (20) drive(1'b1, 2);
        chk("stuck_err_cnt", err_cnt, 0);
        chk("stuck_pulses", pulse_cnt, 0);
        chk("stuck_hold", stuck, 1);

        // Continuously inverted stream saturates a 4-bit counter.
        relock(1'b0);
        repeat (150) drive(1'b1, 1);
        chk("sat_reach", err_cnt, 15);
        repeat (100) drive(1'b1, 1);
        chk("sat_hold", err_cnt, 15);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (err_pulse && locked) begin
                found = 1'b1;
                break;
            end
            drive(1'b1, 1);
        end
        chk("sat_found_check", found, 1);
        err_clr = 1'b1;
        drive(1'b1, 1);
        err_clr = 1'b0;
        chk("clr_wins_err_cnt", err_cnt, 0);
        chk("clr_wins_sync_lost", sync_lost, 0);

        // 50% rx_valid: lock timing counted in valid bits.
        relock(1'b1);
        pulse_cnt = 0;
        repeat (100) begin
            drive(1'b1, 0);
            drive(1'b0, 0);
        end
        chk("gap_err_cnt", err_cnt, 0);
        chk("gap_pulses", pulse_cnt, 0);
        chk("gap_locked", locked, 1);

        // Reset mid-CHECK while an error is in flight.
        drive(1'b1, 1);
        chk("pre_rst_err_cnt", err_cnt, 1);
        rst = 1'b1;
        drive(1'b1, 1);
        rst = 1'b0;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_stuck", stuck, 0);
        chk("mid_rst_err_pulse", err_pulse, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_sync_lost", sync_lost, 0);
        drive(1'b0, 0);
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 0);
            if (i == 29) chk("post_rst_lock_early", locked, 0);
        end
        chk("post_rst_lock", locked, 1);
        repeat (50) drive(1'b1, 0);
        chk("post_rst_err_cnt", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
